// File: rtl/local_history_table_pkg.sv
// Shared branch-predictor types and constants for the local history table.
package local_history_table_pkg;

  localparam int CONF_BRANCH_HIST_WIDTH = 5;
  localparam int CONF_LHT_ENTRY_NUM     = 256;
  localparam int CONF_LHT_INDEX_WIDTH   = $clog2(CONF_LHT_ENTRY_NUM);

  typedef logic [CONF_BRANCH_HIST_WIDTH-1:0] LocalHistoryPath;
  typedef logic [CONF_LHT_INDEX_WIDTH-1:0]   LocalHistoryIndexPath;

  typedef enum logic {
    LHT_PHASE_INIT  = 1'b0,
    LHT_PHASE_READY = 1'b1
  } LocalHistoryTablePhase;

endpackage

// File: rtl/local_history_ram.sv
// History storage: one shift/clear write port, LANE_NUM synchronous read ports.
// Read-during-write on the same entry returns the old contents.
module local_history_ram #(
  parameter int ENTRY_NUM  = 256,
  parameter int HIST_WIDTH = 5,
  parameter int LANE_NUM   = 2,
  localparam int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [IDX_W-1:0]                     waddr,
  input  logic                                 wclear,
  input  logic                                 wbit,
  input  logic [LANE_NUM-1:0][IDX_W-1:0]       raddr,
  output logic [LANE_NUM-1:0][HIST_WIDTH-1:0]  rdata
);

  logic [HIST_WIDTH-1:0] mem [ENTRY_NUM];

  // The write port shifts in place, so the update path needs no extra read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wclear ? '0 : {mem[waddr][HIST_WIDTH-2:0], wbit};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE_NUM; i++) rdata[i] <= mem[raddr[i]];
  end

endmodule

// File: rtl/local_history_table.sv
// Local history table: init FSM, PC index generation and optional update bypass.
// RSD_MARCH_LHT_BYPASS_EN: same-cycle lookup sees the history written by that cycle's update.
module local_history_table
  import local_history_table_pkg::*;
#(
  parameter int ENTRY_NUM  = CONF_LHT_ENTRY_NUM,
  parameter int HIST_WIDTH = CONF_BRANCH_HIST_WIDTH,
  parameter int LANE_NUM   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [LANE_NUM-1:0]                 lookupValid,
  input  logic [LANE_NUM-1:0][31:0]           lookupPC,
  output logic [LANE_NUM-1:0][HIST_WIDTH-1:0] lookupHist,
  output logic [LANE_NUM-1:0]                 lookupHistValid,
  input  logic                                updateValid,
  input  logic [31:0]                         updatePC,
  input  logic                                updateTaken,
  output logic                                busy
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam logic [IDX_W:0] INIT_LAST = (IDX_W+1)'(ENTRY_NUM - 1);

  LocalHistoryTablePhase state, state_nxt;
  logic [IDX_W:0] initCounter, init_counter_nxt;

  logic [LANE_NUM-1:0][IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]                    upd_idx;
  logic [LANE_NUM-1:0][HIST_WIDTH-1:0] rd_data;
  logic [LANE_NUM-1:0][HIST_WIDTH-1:0] hist_raw;
  logic [1:0][LANE_NUM-1:0]            vld_pipe;
  logic                                unused_pc_bits;

  assign busy = (state == LHT_PHASE_INIT);

  always_comb begin
    for (int i = 0; i < LANE_NUM; i++) rd_idx[i] = lookupPC[i][IDX_W+1:2];
  end
  assign upd_idx        = updatePC[IDX_W+1:2];
  assign unused_pc_bits = ^{lookupPC, updatePC};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LHT_PHASE_INIT;
      initCounter <= '0;
    end else begin
      state       <= state_nxt;
      initCounter <= init_counter_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    init_counter_nxt = initCounter;
    case (state)
      LHT_PHASE_INIT: begin
        init_counter_nxt = initCounter + 1'b1;
        if (initCounter == INIT_LAST) state_nxt = LHT_PHASE_READY;
      end
      default: ;
    endcase
  end

  // Init owns the write port; updates arriving while busy are dropped.
  local_history_ram #(
    .ENTRY_NUM (ENTRY_NUM),
    .HIST_WIDTH(HIST_WIDTH),
    .LANE_NUM  (LANE_NUM)
  ) u_ram (
    .clk   (clk),
    .we    (busy | updateValid),
    .waddr (busy ? initCounter[IDX_W-1:0] : upd_idx),
    .wclear(busy),
    .wbit  (updateTaken),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign vld_pipe[0] = lookupValid & {LANE_NUM{~busy}};

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe[1] <= '0;
    else        vld_pipe[1] <= vld_pipe[0];
  end

`ifdef RSD_MARCH_LHT_BYPASS_EN
  logic [LANE_NUM-1:0] byp_q;
  logic                byp_taken_q;

  always_ff @(posedge clk) begin
    if (!rst_n) byp_q <= '0;
    else for (int i = 0; i < LANE_NUM; i++)
      byp_q[i] <= updateValid & ~busy & (rd_idx[i] == upd_idx);
    byp_taken_q <= updateTaken;
  end

  // RAM returned the pre-update entry; apply the same shift on the way out.
  always_comb begin
    for (int i = 0; i < LANE_NUM; i++)
      hist_raw[i] = byp_q[i] ? {rd_data[i][HIST_WIDTH-2:0], byp_taken_q} : rd_data[i];
  end
`else
  assign hist_raw = rd_data;
`endif

  always_comb begin
    for (int i = 0; i < LANE_NUM; i++) lookupHist[i] = vld_pipe[1][i] ? hist_raw[i] : '0;
  end
  assign lookupHistValid = vld_pipe[1];

endmodule
